spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave's 10-bit command stream, a second local requester, and one single-port RAM.
- Decodes SPI commands and holds separate SPI write and read address registers.
- Queues SPI memory operations in a 1-entry slot and round-robins RAM ownership between SPI and the local port.
- Returns SPI read data on the SPI slave's tx_data/tx_valid interface.

Parameters:
- ADDR_WIDTH, 8, RAM address width. Legal range 1..8; the SPI payload uses bits [ADDR_WIDTH-1:0].

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spi_rx_data  in  10  SPI frame: [9:8] command, [7:0] payload.
- spi_rx_valid  in  1  one-cycle strobe qualifying spi_rx_data.
- spi_tx_data  out  8  read data returned to the SPI slave.
- spi_tx_valid  out  1  one-cycle strobe qualifying spi_tx_data.
- spi_drop  out  1  one-cycle pulse when an SPI memory command is discarded.
- loc_req  in  1  local request, held until granted.
- loc_we  in  1  local op type: 1 = write, 0 = read.
- loc_addr  in  ADDR_WIDTH  local address.
- loc_wdata  in  8  local write data.
- loc_gnt  out  1  one-cycle grant pulse.
- loc_rdata  out  8  local read data.
- loc_rvalid  out  1  one-cycle strobe qualifying loc_rdata.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after ram_en=1 with ram_we=0.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; slot empty; wr_addr and rd_addr = 0; last_gnt = LOC.
  - All outputs 0, including spi_tx_data and loc_rdata.
  - Any in-flight access is abandoned; no tx_valid or rvalid follows.
- SPI decode, on an edge where spi_rx_valid=1:
  - cmd 00: wr_addr <= payload. Never blocked.
  - cmd 10: rd_addr <= payload. Never blocked.
  - cmd 01: slot <= {write, wr_addr, payload[7:0]}.
  - cmd 11: slot <= {read, rd_addr}; payload ignored.
  - The slot captures the address value at decode; a later cmd 00/10 does not alter a queued op.
- Slot full:
  - A cmd 01 or 11 arriving while the slot is full is discarded; spi_drop pulses for the following cycle.
  - Exception: if the slot is being granted on that same edge, the new command is accepted, with no drop.
- FSM states: IDLE, SPI_OP, SPI_RD, LOC_OP, LOC_RD.
  - IDLE: candidates are slot-full and loc_req. If only one is present, it wins. If both are present, the one not equal to last_gnt wins. The winner is written to last_gnt and the FSM moves to SPI_OP or LOC_OP. A SPI win clears the slot on that edge. Local op fields are sampled on that edge.
  - SPI_OP / LOC_OP (exactly one cycle): ram_en=1, ram_we = op write, ram_addr and ram_wdata registered. loc_gnt=1 during LOC_OP only. Next state is IDLE for a write, SPI_RD or LOC_RD for a read.
  - SPI_RD / LOC_RD (one cycle): ram_en=0. On the exiting edge, spi_tx_data or loc_rdata <= ram_rdata, and spi_tx_valid or loc_rvalid pulses 1 the next cycle. Next state IDLE.
- Outside the OP states, ram_en and ram_we are 0; ram_addr and ram_wdata hold their last values.
- Latency, with E0 = the edge that samples spi_rx_valid:
  - SPI read: ram_en after E1; spi_tx_valid high in the cycle after E3.
  - SPI write: RAM written on E2.
  - Local read: loc_rvalid two cycles after loc_gnt.
  - Back-to-back ops have one IDLE cycle between them.
- Local handshake:
  - Requester holds loc_req, loc_we, loc_addr and loc_wdata stable until it sees loc_gnt=1.
  - It deasserts loc_req on the edge ending the grant cycle; if loc_req is still high in IDLE, it is a new request.
- Output pulses: spi_tx_valid, loc_rvalid, loc_gnt and spi_drop never exceed one cycle. Data outputs hold between strobes.

Test Plan:
- SPI writes (0x000, 0x1A5), then reads (0x200, 0x300) -> RAM[0x00] written 0xA5; spi_tx_valid pulse with spi_tx_data=0xA5 the cycle after E3 of the 0x300 frame.
- Local write addr 0x10 data 0x3C, then local read 0x10 -> loc_gnt twice; loc_rvalid with loc_rdata=0x3C two cycles after the second grant.
- Slot full: SPI read queued behind an in-progress local read, second 0x3xx arrives before the grant -> spi_drop one pulse; exactly one spi_tx_valid.
- SPI slot and loc_req both pending in IDLE after reset -> SPI granted first (last_gnt=LOC); next contention -> LOC granted; order alternates.
- Write-address 0x005, data 0x177 queued, then write-address 0x009 before the grant -> RAM[0x05]=0x77; RAM[0x09] unchanged.
- rst_n asserted during SPI_RD -> all outputs 0 immediately; no spi_tx_valid after release; next command serviced normally from IDLE.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares one single-port RAM between the SPI slave command stream and a
//   local requester. SPI commands set write/read address registers or queue
//   one memory op in a single-entry slot. Ownership alternates round-robin
//   when both sides are waiting.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   spi_rx_data/spi_rx_valid   10-bit SPI frame {cmd[1:0], payload[7:0]}
//   spi_tx_data/spi_tx_valid   SPI read data back to the slave
//   spi_drop                   pulse: SPI memory command discarded (slot full)
//   loc_req/we/addr/wdata      local request, held until loc_gnt
//   loc_gnt                    grant pulse (the cycle the RAM is driven)
//   loc_rdata/loc_rvalid       local read data
//   ram_*                      single-port RAM, read data one cycle after ram_en
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitrate between queued SPI slot and loc_req
// SPI_OP | RAM driven with the SPI slot op
// SPI_RD | wait for RAM read data, return it on spi_tx_*
// LOC_OP | RAM driven with the local op, loc_gnt high
// LOC_RD | wait for RAM read data, return it on loc_r*

module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            spi_rx_data,
    input  logic                  spi_rx_valid,
    output logic [7:0]            spi_tx_data,
    output logic                  spi_tx_valid,
    output logic                  spi_drop,
    input  logic                  loc_req,
    input  logic                  loc_we,
    input  logic [ADDR_WIDTH-1:0] loc_addr,
    input  logic [7:0]            loc_wdata,
    output logic                  loc_gnt,
    output logic [7:0]            loc_rdata,
    output logic                  loc_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPI_OP = 3'd1,
        SPI_RD = 3'd2,
        LOC_OP = 3'd3,
        LOC_RD = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [1:0]            cmd;
    logic [7:0]            payload;
    logic                  mem_cmd;
    logic                  accept;
    logic                  grant_spi;
    logic                  grant_loc;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  slot_full;
    logic                  slot_we;
    logic [ADDR_WIDTH-1:0] slot_addr;
    logic [7:0]            slot_data;

    logic                  last_gnt_loc;
    logic                  op_we;

    assign cmd     = spi_rx_data[9:8];
    assign payload = spi_rx_data[7:0];

    // cmd[0]=1 marks a memory command (01 write, 11 read)
    assign mem_cmd = spi_rx_valid && cmd[0];
    // A full slot that is leaving on this edge can take the new command
    assign accept  = mem_cmd && (!slot_full || grant_spi);

    always_comb begin
        state_nxt = state;
        grant_spi = 1'b0;
        grant_loc = 1'b0;
        case (state)
            IDLE: begin
                // SPI wins if alone, or if both wait and LOC had the last turn
                if (slot_full && (!loc_req || last_gnt_loc)) begin
                    grant_spi = 1'b1;
                    state_nxt = SPI_OP;
                end else if (loc_req) begin
                    grant_loc = 1'b1;
                    state_nxt = LOC_OP;
                end
            end
            SPI_OP:  state_nxt = op_we ? IDLE : SPI_RD;
            LOC_OP:  state_nxt = op_we ? IDLE : LOC_RD;
            SPI_RD:  state_nxt = IDLE;
            LOC_RD:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SPI address registers and the one-entry op slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            slot_full <= 1'b0;
            slot_we   <= 1'b0;
            slot_addr <= '0;
            slot_data <= '0;
            spi_drop  <= 1'b0;
        end else begin
            if (spi_rx_valid && cmd == 2'b00) begin
                wr_addr <= payload[ADDR_WIDTH-1:0];
            end
            if (spi_rx_valid && cmd == 2'b10) begin
                rd_addr <= payload[ADDR_WIDTH-1:0];
            end
            if (grant_spi) begin
                slot_full <= 1'b0;
            end
            if (accept) begin
                slot_full <= 1'b1;
                slot_we   <= ~cmd[1];
                slot_addr <= cmd[1] ? rd_addr : wr_addr;
                slot_data <= payload;
            end
            spi_drop <= mem_cmd && !accept;
        end
    end

    // Op registers loaded on the grant edge; RAM address/data hold afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_loc <= 1'b1;
            op_we        <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else if (grant_spi) begin
            last_gnt_loc <= 1'b0;
            op_we        <= slot_we;
            ram_addr     <= slot_addr;
            ram_wdata    <= slot_data;
        end else if (grant_loc) begin
            last_gnt_loc <= 1'b1;
            op_we        <= loc_we;
            ram_addr     <= loc_addr;
            ram_wdata    <= loc_wdata;
        end
    end

    // Read return paths
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            loc_rdata    <= '0;
            loc_rvalid   <= 1'b0;
        end else begin
            spi_tx_valid <= (state == SPI_RD);
            loc_rvalid   <= (state == LOC_RD);
            if (state == SPI_RD) begin
                spi_tx_data <= ram_rdata;
            end
            if (state == LOC_RD) begin
                loc_rdata <= ram_rdata;
            end
        end
    end

    assign ram_en  = (state == SPI_OP) || (state == LOC_OP);
    assign ram_we  = ram_en && op_we;
    assign loc_gnt = (state == LOC_OP);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a synchronous-read RAM model.
module tb_spi_ram_arbiter;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic [9:0]    spi_rx_data;
    logic          spi_rx_valid;
    logic [7:0]    spi_tx_data;
    logic          spi_tx_valid;
    logic          spi_drop;
    logic          loc_req;
    logic          loc_we;
    logic [AW-1:0] loc_addr;
    logic [7:0]    loc_wdata;
    logic          loc_gnt;
    logic [7:0]    loc_rdata;
    logic          loc_rvalid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    logic [7:0]    mem [256];
    logic          mem_clear;

    int tests = 0;
    int fails = 0;
    int tx_cnt = 0;
    int drop_cnt = 0;
    int tx_snap;
    int drop_snap;

    spi_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_valid (spi_tx_valid),
        .spi_drop     (spi_drop),
        .loc_req      (loc_req),
        .loc_we       (loc_we),
        .loc_addr     (loc_addr),
        .loc_wdata    (loc_wdata),
        .loc_gnt      (loc_gnt),
        .loc_rdata    (loc_rdata),
        .loc_rvalid   (loc_rvalid),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
            ram_rdata <= 8'h00;
        end else if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (spi_tx_valid) tx_cnt <= tx_cnt + 1;
        if (spi_drop) drop_cnt <= drop_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] f);
        spi_rx_data  = f;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        spi_rx_data  = 10'h000;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, spi_tx_data, spi_tx_valid, spi_drop, loc_gnt, loc_rdata,
                loc_rvalid, ram_en, ram_we, ram_addr, ram_wdata};
    endfunction

    initial begin
        rst_n        = 1'b0;
        mem_clear    = 1'b1;
        spi_rx_data  = 10'h000;
        spi_rx_valid = 1'b0;
        loc_req      = 1'b0;
        loc_we       = 1'b0;
        loc_addr     = '0;
        loc_wdata    = 8'h00;
        repeat (2) tick();
        check("reset_outputs", all_outs(), 64'd0);
        mem_clear = 1'b0;
        rst_n     = 1'b1;
        tick();

        // SPI write then read of address 0
        send(10'h000);
        send(10'h1A5);
        check("t1_idle_before_grant", {63'd0, ram_en}, 64'd0);
        tick();
        check("t1_wr_en", {62'd0, ram_en, ram_we}, 64'd3);
        check("t1_wr_addr", {56'd0, ram_addr}, 64'h00);
        check("t1_wr_data", {56'd0, ram_wdata}, 64'hA5);
        tick();
        check("t1_mem0", {56'd0, mem[0]}, 64'hA5);
        check("t1_en_off", {63'd0, ram_en}, 64'd0);
        send(10'h200);
        send(10'h300);
        tick();
        check("t1_rd_en", {62'd0, ram_en, ram_we}, 64'd2);
        tick();
        check("t1_tx_not_early", {63'd0, spi_tx_valid}, 64'd0);
        tick();
        check("t1_tx", {55'd0, spi_tx_valid, spi_tx_data}, {55'd0, 1'b1, 8'hA5});
        tick();
        check("t1_tx_end", {55'd0, spi_tx_valid, spi_tx_data}, {55'd0, 1'b0, 8'hA5});

        // Local write then read of 0x10
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h10; loc_wdata = 8'h3C;
        tick();
        check("t2_gnt_w", {61'd0, loc_gnt, ram_en, ram_we}, 64'd7);
        check("t2_addr_w", {56'd0, ram_addr}, 64'h10);
        loc_req = 1'b0;
        tick();
        check("t2_gnt_w_end", {63'd0, loc_gnt}, 64'd0);
        check("t2_mem10", {56'd0, mem[8'h10]}, 64'h3C);
        loc_req = 1'b1; loc_we = 1'b0;
        tick();
        check("t2_gnt_r", {61'd0, loc_gnt, ram_en, ram_we}, 64'd6);
        loc_req = 1'b0;
        tick();
        check("t2_rvalid_early", {63'd0, loc_rvalid}, 64'd0);
        tick();
        check("t2_rvalid", {55'd0, loc_rvalid, loc_rdata}, {55'd0, 1'b1, 8'h3C});
        tick();
        check("t2_rvalid_end", {63'd0, loc_rvalid}, 64'd0);

        // Round-robin contention; new SPI cmd accepted on the slot's grant edge
        drop_snap = drop_cnt;
        send(10'h030);
        send(10'h166);
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h20; loc_wdata = 8'h11;
        spi_rx_data = 10'h177; spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        check("t3_spi_first", {47'd0, loc_gnt, ram_addr, ram_wdata}, {47'd0, 1'b0, 8'h30, 8'h66});
        check("t3_no_drop", {63'd0, spi_drop}, 64'd0);
        tick();
        check("t3_mem30_a", {56'd0, mem[8'h30]}, 64'h66);
        tick();
        check("t3_loc_second", {47'd0, loc_gnt, ram_addr, ram_wdata}, {47'd0, 1'b1, 8'h20, 8'h11});
        loc_req = 1'b0;
        tick();
        check("t3_mem20", {56'd0, mem[8'h20]}, 64'h11);
        tick();
        check("t3_spi_third", {46'd0, ram_en, loc_gnt, ram_addr, ram_wdata}, {46'd0, 1'b1, 1'b0, 8'h30, 8'h77});
        tick();
        check("t3_mem30_b", {56'd0, mem[8'h30]}, 64'h77);
        check("t3_drop_count", 64'(drop_cnt - drop_snap), 64'd0);

        // Slot full behind a local read -> one drop, one tx
        send(10'h230);
        tx_snap = tx_cnt;
        drop_snap = drop_cnt;
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h20;
        tick();
        check("t4_gnt", {63'd0, loc_gnt}, 64'd1);
        loc_req = 1'b0;
        send(10'h300);
        send(10'h3FF);
        check("t4_drop", {63'd0, spi_drop}, 64'd1);
        check("t4_loc_rd", {55'd0, loc_rvalid, loc_rdata}, {55'd0, 1'b1, 8'h11});
        tick();
        check("t4_drop_end", {63'd0, spi_drop}, 64'd0);
        check("t4_spi_rd", {54'd0, ram_en, ram_we, ram_addr}, {54'd0, 1'b1, 1'b0, 8'h30});
        tick();
        tick();
        check("t4_tx", {55'd0, spi_tx_valid, spi_tx_data}, {55'd0, 1'b1, 8'h77});
        repeat (3) tick();
        check("t4_tx_count", 64'(tx_cnt - tx_snap), 64'd1);
        check("t4_drop_count", 64'(drop_cnt - drop_snap), 64'd1);

        // Queued write keeps its captured address
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h40;
        send(10'h005);
        check("t5_gnt", {63'd0, loc_gnt}, 64'd1);
        loc_req = 1'b0;
        send(10'h177);
        send(10'h009);
        check("t5_loc_rd", {55'd0, loc_rvalid, loc_rdata}, {55'd0, 1'b1, 8'hEE});
        check("t5_no_drop", {63'd0, spi_drop}, 64'd0);
        tick();
        check("t5_spi_wr", {46'd0, ram_en, ram_we, ram_addr, ram_wdata}, {46'd0, 1'b1, 1'b1, 8'h05, 8'h77});
        tick();
        check("t5_mem05", {56'd0, mem[8'h05]}, 64'h77);
        check("t5_mem09", {56'd0, mem[8'h09]}, 64'hEE);

        // Reset during SPI_RD
        send(10'h209);
        send(10'h300);
        tick();
        check("t6_rd_addr", {55'd0, ram_en, ram_addr}, {55'd0, 1'b1, 8'h09});
        tick();
        tx_snap = tx_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", all_outs(), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_no_tx", 64'(tx_cnt - tx_snap), 64'd0);
        send(10'h1C3);
        tick();
        check("t6_wr_after_reset", {47'd0, ram_we, ram_addr, ram_wdata}, {47'd0, 1'b1, 8'h00, 8'hC3});
        tick();
        check("t6_mem00", {56'd0, mem[0]}, 64'hC3);
        send(10'h300);
        tick();
        tick();
        tick();
        check("t6_tx", {55'd0, spi_tx_valid, spi_tx_data}, {55'd0, 1'b1, 8'hC3});
        tick();
        check("t6_tx_end", {63'd0, spi_tx_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
